// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared mode encodings and index-width helper for stream_mux_rr
package stream_mux_pkg;

    localparam int MODE_RR  = 0;
    localparam int MODE_SEL = 1;

    // Channel-index width; never narrower than one bit.
    function automatic int calc_selw(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant, searching upward from last+1 with wrap
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = calc_selw(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] last,
    output logic [N-1:0]    grant
);

    always_comb begin : search
        int   idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N:1 stream mux with registered output, round-robin or external select.
// Optional packet locking (in_last/out_last) enabled by macro STREAM_MUX_LOCK_EN.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int  WIDTH    = 8,
    parameter int  CHANNELS = 4,
    parameter int  MODE     = MODE_RR,
    localparam int SELW     = calc_selw(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SELW-1:0]           sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SELW-1:0]           out_chan
`ifdef STREAM_MUX_LOCK_EN
    ,
    input  logic [CHANNELS-1:0]       in_last,
    output logic                      out_last
`endif
);

    logic [CHANNELS-1:0] w_rr_grant;
    logic [CHANNELS-1:0] w_sel_grant;
    logic [CHANNELS-1:0] w_mode_grant;
    logic [CHANNELS-1:0] w_grant;
    logic                w_free;
    logic                w_xfer;
    logic [SELW-1:0]     w_gidx;
    logic [WIDTH-1:0]    w_gdata;

    logic [SELW-1:0]     r_last;
    logic [WIDTH-1:0]    r_out_data;
    logic                r_out_valid;
    logic [SELW-1:0]     r_out_chan;

    rr_arbiter #(
        .N    (CHANNELS),
        .SELW (SELW)
    ) u_arb (
        .req   (in_valid),
        .last  (r_last),
        .grant (w_rr_grant)
    );

    // Out-of-range sel matches no channel, so nothing is granted.
    always_comb begin
        w_sel_grant = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_sel_grant[i] = (int'(sel) == i);
        end
    end

    assign w_mode_grant = (MODE == MODE_SEL) ? w_sel_grant : w_rr_grant;

`ifdef STREAM_MUX_LOCK_EN
    logic            r_locked;
    logic [SELW-1:0] r_lock_chan;
    logic            r_out_last;
    logic            w_glast;

    // A packet in flight pins the grant to its channel regardless of mode.
    always_comb begin
        w_grant = w_mode_grant;
        if (r_locked) begin
            for (int i = 0; i < CHANNELS; i++) begin
                w_grant[i] = (int'(r_lock_chan) == i);
            end
        end
    end

    assign w_glast = |(in_last & w_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked    <= 1'b0;
            r_lock_chan <= '0;
            r_out_last  <= 1'b0;
        end else if (w_xfer) begin
            r_locked    <= !w_glast;
            r_lock_chan <= w_gidx;
            r_out_last  <= w_glast;
        end
    end

    assign out_last = r_out_last;
`else
    assign w_grant = w_mode_grant;
`endif

    assign w_free   = !r_out_valid || out_ready;
    assign in_ready = w_grant & {CHANNELS{w_free}};
    assign w_xfer   = w_free && (|(in_valid & w_grant));

    always_comb begin
        w_gidx  = '0;
        w_gdata = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant[i]) begin
                w_gidx  = SELW'(i);
                w_gdata = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_last      <= SELW'(CHANNELS - 1);
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gdata;
            r_out_chan  <= w_gidx;
            r_last      <= w_gidx;
        end else if (w_free) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - table-driven bench for stream_mux_rr in round-robin and select modes
module tb_stream_mux_rr;

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        oready;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [1:0]  exp_chan;
        logic [7:0]  exp_data;
    } vec_t;

    localparam logic [31:0] D  = 32'hD3C2B1A0;
    localparam logic [31:0] D2 = 32'hD3C2A5A0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] a_data, b_data;
    logic [3:0]  a_valid, b_valid;
    logic [3:0]  a_rdy, b_rdy;
    logic [1:0]  a_sel, b_sel;
    logic [7:0]  a_odata, b_odata;
    logic        a_ovalid, b_ovalid;
    logic        a_oready, b_oready;
    logic [1:0]  a_ochan, b_ochan;
`ifdef STREAM_MUX_LOCK_EN
    logic [3:0]  a_last, b_last;
    logic        a_olast, b_olast;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    vec_t rr_tab[19];
    vec_t sel_tab[5];

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_rdy),
        .sel(a_sel), .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_oready),
        .out_chan(a_ochan)
`ifdef STREAM_MUX_LOCK_EN
        , .in_last(a_last), .out_last(a_olast)
`endif
    );

    stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_sel (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_rdy),
        .sel(b_sel), .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_oready),
        .out_chan(b_ochan)
`ifdef STREAM_MUX_LOCK_EN
        , .in_last(b_last), .out_last(b_olast)
`endif
    );

    function automatic vec_t mk(input logic [1:0] s, input logic [3:0] v, input logic [31:0] d,
                                input logic r, input logic [3:0] er, input logic ev,
                                input logic [1:0] ec, input logic [7:0] ed);
        vec_t t;
        t.sel = s; t.valid = v; t.data = d; t.oready = r;
        t.exp_rdy = er; t.exp_ov = ev; t.exp_chan = ec; t.exp_data = ed;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; checks in_ready before the rising edge, outputs just after it.
    task automatic run_vec(input vec_t v, input bit use_sel, input int i);
        string tag;
        tag = use_sel ? $sformatf("sel[%0d]", i) : $sformatf("rr[%0d]", i);
        if (use_sel) begin
            b_sel = v.sel; b_valid = v.valid; b_data = v.data; b_oready = v.oready;
        end else begin
            a_valid = v.valid; a_data = v.data; a_oready = v.oready;
        end
        #1;
        chk({tag, " in_ready"}, 32'(use_sel ? b_rdy : a_rdy), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 32'(use_sel ? b_ovalid : a_ovalid), 32'(v.exp_ov));
        if (v.exp_ov) begin
            chk({tag, " out_chan"}, 32'(use_sel ? b_ochan : a_ochan), 32'(v.exp_chan));
            chk({tag, " out_data"}, 32'(use_sel ? b_odata : a_odata), 32'(v.exp_data));
        end
        @(negedge clk);
    endtask

    initial begin
        rr_tab[0]  = mk(0, 4'b1111, D,  1, 4'b0001, 1, 0, 8'hA0);
        rr_tab[1]  = mk(0, 4'b1111, D,  1, 4'b0010, 1, 1, 8'hB1);
        rr_tab[2]  = mk(0, 4'b1111, D,  1, 4'b0100, 1, 2, 8'hC2);
        rr_tab[3]  = mk(0, 4'b1111, D,  1, 4'b1000, 1, 3, 8'hD3);
        rr_tab[4]  = mk(0, 4'b1111, D,  1, 4'b0001, 1, 0, 8'hA0);
        rr_tab[5]  = mk(0, 4'b0010, D,  1, 4'b0010, 1, 1, 8'hB1);
        rr_tab[6]  = mk(0, 4'b1010, D,  1, 4'b1000, 1, 3, 8'hD3);
        rr_tab[7]  = mk(0, 4'b1010, D,  1, 4'b0010, 1, 1, 8'hB1);
        rr_tab[8]  = mk(0, 4'b1010, D,  1, 4'b1000, 1, 3, 8'hD3);
        rr_tab[9]  = mk(0, 4'b0000, D,  1, 4'b0000, 0, 0, 8'h00);
        rr_tab[10] = mk(0, 4'b0001, D,  1, 4'b0001, 1, 0, 8'hA0);
        rr_tab[11] = mk(0, 4'b0010, D2, 1, 4'b0010, 1, 1, 8'hA5);
        rr_tab[12] = mk(0, 4'b1111, D,  0, 4'b0000, 1, 1, 8'hA5);
        rr_tab[13] = mk(0, 4'b1111, D,  0, 4'b0000, 1, 1, 8'hA5);
        rr_tab[14] = mk(0, 4'b1111, D,  0, 4'b0000, 1, 1, 8'hA5);
        rr_tab[15] = mk(0, 4'b1111, D,  1, 4'b0100, 1, 2, 8'hC2);
        rr_tab[16] = mk(0, 4'b0000, D,  1, 4'b0000, 0, 0, 8'h00);
        rr_tab[17] = mk(0, 4'b0000, D,  0, 4'b0000, 0, 0, 8'h00);
        rr_tab[18] = mk(0, 4'b0100, D,  0, 4'b0100, 1, 2, 8'hC2);

        sel_tab[0] = mk(2, 4'b0101, D,  1, 4'b0100, 1, 2, 8'hC2);
        sel_tab[1] = mk(1, 4'b0101, D,  1, 4'b0010, 0, 0, 8'h00);
        sel_tab[2] = mk(3, 4'b1000, D,  0, 4'b1000, 1, 3, 8'hD3);
        sel_tab[3] = mk(0, 4'b0001, D,  0, 4'b0000, 1, 3, 8'hD3);
        sel_tab[4] = mk(0, 4'b0001, D,  1, 4'b0001, 1, 0, 8'hA0);

        a_data = D; a_valid = '0; a_sel = '0; a_oready = 1'b1;
        b_data = D; b_valid = '0; b_sel = '0; b_oready = 1'b1;
`ifdef STREAM_MUX_LOCK_EN
        a_last = '0;
        b_last = '1;
`endif

        repeat (2) @(negedge clk);
        #1;
        chk("reset out_valid", 32'(a_ovalid), 32'(0));
        chk("reset out_data",  32'(a_odata),  32'(0));
        chk("reset out_chan",  32'(a_ochan),  32'(0));
        chk("reset in_ready",  32'(a_rdy),    32'(0));
        chk("reset sel out_valid", 32'(b_ovalid), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 19; i++) run_vec(rr_tab[i], 1'b0, i);
        for (int i = 0; i < 5; i++)  run_vec(sel_tab[i], 1'b1, i);

        // Asynchronous reset while a beat is stalled at the output.
        a_valid = 4'b0010;
        a_oready = 1'b0;
        #1;
        chk("pre-reset out_valid", 32'(a_ovalid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 32'(a_ovalid), 32'(0));
        chk("async reset out_data",  32'(a_odata),  32'(0));
        chk("async reset out_chan",  32'(a_ochan),  32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        a_valid = 4'b0000;
        a_oready = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset no beat", 32'(a_ovalid), 32'(0));
        @(negedge clk);
        a_valid = 4'b1111;
        #1;
        chk("post-reset grant", 32'(a_rdy), 32'(4'b0001));
        @(posedge clk);
        #1;
        chk("post-reset out_chan",  32'(a_ochan),  32'(0));
        chk("post-reset out_valid", 32'(a_ovalid), 32'(1));
        @(negedge clk);

`ifdef STREAM_MUX_LOCK_EN
        begin
            logic [1:0] lk_chan [4];
            logic [3:0] lk_last [4];
            lk_chan[0] = 2'd1; lk_chan[1] = 2'd1; lk_chan[2] = 2'd1; lk_chan[3] = 2'd0;
            lk_last[0] = 4'b0000; lk_last[1] = 4'b0000; lk_last[2] = 4'b0010; lk_last[3] = 4'b0000;
            a_valid = 4'b0011;
            a_oready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                a_last = lk_last[i];
                @(posedge clk);
                #1;
                chk($sformatf("lock[%0d] out_chan", i), 32'(a_ochan), 32'(lk_chan[i]));
                chk($sformatf("lock[%0d] out_last", i), 32'(a_olast), 32'(lk_last[i] != 4'b0000));
                @(negedge clk);
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
